// File: rtl/fft_pkg.sv
// Shared fixed-point helpers for SDF pipeline stages: widths, limits, saturating negate.
// Purely combinational definitions, zero latency.
// No flow control.
package fft_pkg;
    localparam int INTEGER_SIZE_DEF = 6;
    localparam int FRACT_SIZE_DEF = 12;
    localparam int NEG_W = 64;

    localparam logic DIR_FFT = 1'b0;
    localparam logic DIR_IFFT = 1'b1;

    function automatic int data_width(input int integer_size, input int fract_size);
        return integer_size + fract_size;
    endfunction

    localparam int DATA_WIDTH = data_width(INTEGER_SIZE_DEF, FRACT_SIZE_DEF);

    typedef logic signed [NEG_W-1:0] wide_t;

    typedef struct packed {
        wide_t value;
        logic  sat;
    } neg_t;

    function automatic wide_t max_pos(input int w);
        wide_t one;
        one = wide_t'(1);
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic wide_t max_neg(input int w);
        return -max_pos(w) - wide_t'(1);
    endfunction

    localparam wide_t MAX_POS = max_pos(DATA_WIDTH);
    localparam wide_t MAX_NEG = max_neg(DATA_WIDTH);

    // Operates on a sign-extended sample so one helper serves every width.
    function automatic neg_t sat_neg(input wide_t x, input int w);
        neg_t res;
        if (x == max_neg(w)) begin
            res.value = max_pos(w);
            res.sat   = 1'b1;
        end else begin
            res.value = -x;
            res.sat   = 1'b0;
        end
        return res;
    endfunction
endpackage

// File: rtl/delay_unit.sv
// Single register stage used to build fixed-latency delay lines.
// Latency 1 cycle.
// No backpressure; free-running.
module delay_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else
            q <= d;
    end
endmodule

// File: rtl/sdf_trivial_rotator.sv
// SDF trivial twiddle stage: identity or +/-j rotation on the last quarter of each block.
// Latency PIPE_STAGES cycles; sat_flag updates one cycle after the input.
// No backpressure; accepts one sample per cycle, gaps freeze the schedule.
module sdf_trivial_rotator
    import fft_pkg::*;
#(
    parameter int INTEGER_SIZE = 6,
    parameter int FRACT_SIZE   = 12,
    parameter int BLOCK        = 64,
    parameter int PIPE_STAGES  = 1,
    localparam int DATA_WIDTH  = data_width(INTEGER_SIZE, FRACT_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic                  in_dir,
    input  logic                  in_bypass,
    input  logic [DATA_WIDTH-1:0] in_r,
    input  logic [DATA_WIDTH-1:0] in_i,
    output logic                  out_valid,
    output logic                  out_sof,
    output logic [DATA_WIDTH-1:0] out_r,
    output logic [DATA_WIDTH-1:0] out_i,
    output logic                  sat_flag
);
    localparam int CNT_W = $clog2(BLOCK);
    localparam logic [CNT_W-1:0] ROT_START = CNT_W'(3 * BLOCK / 4);

    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe
        $error("PIPE_STAGES must be in 1..4");
    end
    if (BLOCK < 4 || (BLOCK & (BLOCK - 1)) != 0) begin : g_bad_block
        $error("BLOCK must be a power of two >= 4");
    end

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      eff_cnt;
    logic                  dir_q;
    logic                  dir_eff;
    logic                  sof_vld;
    logic                  rot;
    logic                  sat_evt;
    logic [DATA_WIDTH-1:0] res_r;
    logic [DATA_WIDTH-1:0] res_i;
    neg_t                  neg_r;
    neg_t                  neg_i;
    logic                  unused_neg_hi;

    // A sof sample restarts the schedule and takes the direction presented with it.
    assign sof_vld = in_valid && in_sof;
    assign eff_cnt = sof_vld ? '0 : cnt;
    assign dir_eff = sof_vld ? in_dir : dir_q;
    assign rot     = (eff_cnt >= ROT_START) && !in_bypass;

    assign neg_r = sat_neg(wide_t'($signed(in_r)), DATA_WIDTH);
    assign neg_i = sat_neg(wide_t'($signed(in_i)), DATA_WIDTH);
    assign unused_neg_hi = ^{neg_r.value[NEG_W-1:DATA_WIDTH], neg_i.value[NEG_W-1:DATA_WIDTH]};

    always_comb begin
        res_r   = in_r;
        res_i   = in_i;
        sat_evt = 1'b0;
        if (rot) begin
            if (dir_eff == DIR_IFFT) begin
                res_r   = neg_i.value[DATA_WIDTH-1:0];
                res_i   = in_r;
                sat_evt = in_valid && neg_i.sat;
            end else begin
                res_r   = in_i;
                res_i   = neg_r.value[DATA_WIDTH-1:0];
                sat_evt = in_valid && neg_r.sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            dir_q    <= DIR_IFFT;
            sat_flag <= 1'b0;
        end else if (in_valid) begin
            cnt <= eff_cnt + CNT_W'(1);
            if (in_sof) begin
                dir_q    <= in_dir;
                sat_flag <= sat_evt;
            end else if (sat_evt) begin
                sat_flag <= 1'b1;
            end
        end
    end

    logic [DATA_WIDTH-1:0] r_stg   [PIPE_STAGES+1];
    logic [DATA_WIDTH-1:0] i_stg   [PIPE_STAGES+1];
    logic                  vld_stg [PIPE_STAGES+1];
    logic                  sof_stg [PIPE_STAGES+1];

    assign r_stg[0]   = res_r;
    assign i_stg[0]   = res_i;
    assign vld_stg[0] = in_valid;
    assign sof_stg[0] = sof_vld;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_pipe
        delay_unit #(.WIDTH(DATA_WIDTH)) u_r (.clk(clk), .rst(rst), .d(r_stg[s]), .q(r_stg[s+1]));
        delay_unit #(.WIDTH(DATA_WIDTH)) u_i (.clk(clk), .rst(rst), .d(i_stg[s]), .q(i_stg[s+1]));
        delay_unit #(.WIDTH(1)) u_vld (.clk(clk), .rst(rst), .d(vld_stg[s]), .q(vld_stg[s+1]));
        delay_unit #(.WIDTH(1)) u_sof (.clk(clk), .rst(rst), .d(sof_stg[s]), .q(sof_stg[s+1]));
    end

    assign out_r     = r_stg[PIPE_STAGES];
    assign out_i     = i_stg[PIPE_STAGES];
    assign out_valid = vld_stg[PIPE_STAGES];
    assign out_sof   = sof_stg[PIPE_STAGES];
endmodule

// File: tb/tb_sdf_trivial_rotator.sv
// Scoreboard bench: random and directed frames into two rotators (1 and 3 stage pipes).
// Expected samples are queued at issue time and popped by per-DUT output monitors.
module tb_sdf_trivial_rotator;
    localparam int DW   = 18;
    localparam int BLK  = 64;
    localparam int MINV = -131072;
    localparam int MAXV = 131071;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_sof, in_dir, in_bypass;
    logic [DW-1:0] in_r, in_i;
    logic o1_valid, o1_sof, o1_sat, o3_valid, o3_sof, o3_sat;
    logic [DW-1:0] o1_r, o1_i, o3_r, o3_i;

    sdf_trivial_rotator #(.INTEGER_SIZE(6), .FRACT_SIZE(12), .BLOCK(BLK), .PIPE_STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_dir(in_dir),
        .in_bypass(in_bypass), .in_r(in_r), .in_i(in_i), .out_valid(o1_valid),
        .out_sof(o1_sof), .out_r(o1_r), .out_i(o1_i), .sat_flag(o1_sat));

    sdf_trivial_rotator #(.INTEGER_SIZE(6), .FRACT_SIZE(12), .BLOCK(BLK), .PIPE_STAGES(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_dir(in_dir),
        .in_bypass(in_bypass), .in_r(in_r), .in_i(in_i), .out_valid(o3_valid),
        .out_sof(o3_sof), .out_r(o3_r), .out_i(o3_i), .sat_flag(o3_sat));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int r;
        int i;
        bit sof;
        int cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    int   m_pos;   // valid samples seen since the frame start, modulo BLK
    bit   m_dir;
    bit   m_sat;
    int   n_vec  = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int mneg(input int x, inout bit s);
        if (x == MINV) begin
            s = 1'b1;
            return MAXV;
        end
        return -x;
    endfunction

    task automatic cmp_out(input string tag, input exp_t e, input int lat,
                           input logic [DW-1:0] r, input logic [DW-1:0] i, input logic sof);
        chk({tag, " out_r"}, $signed(r), e.r);
        chk({tag, " out_i"}, $signed(i), e.i);
        chk({tag, " out_sof"}, sof, e.sof);
        chk({tag, " latency"}, cyc - e.cyc, lat);
    endtask

    always @(negedge clk) begin
        if (o1_valid === 1'b1) begin
            if (q1.size() == 0) chk("p1 unexpected out_valid", 1, 0);
            else cmp_out("p1", q1.pop_front(), 1, o1_r, o1_i, o1_sof);
        end
    end

    always @(negedge clk) begin
        if (o3_valid === 1'b1) begin
            if (q3.size() == 0) chk("p3 unexpected out_valid", 1, 0);
            else cmp_out("p3", q3.pop_front(), 3, o3_r, o3_i, o3_sof);
        end
    end

    // Drive one cycle of input, queue the expected result, then check sat_flag after the edge.
    task automatic apply(input bit v, input bit sof, input bit dir, input bit byp,
                         input int r, input int i);
        exp_t e;
        bit   s;
        bit   rot;
        in_valid  = v;
        in_sof    = sof;
        in_dir    = dir;
        in_bypass = byp;
        in_r      = DW'(r);
        in_i      = DW'(i);
        if (v) begin
            if (sof) begin
                m_pos = 0;
                m_dir = dir;
                m_sat = 1'b0;
            end
            rot   = (m_pos >= 3 * BLK / 4) && !byp;
            s     = 1'b0;
            e.r   = r;
            e.i   = i;
            e.sof = sof;
            e.cyc = cyc;
            if (rot) begin
                if (m_dir) begin
                    e.r = mneg(i, s);
                    e.i = r;
                end else begin
                    e.r = i;
                    e.i = mneg(r, s);
                end
            end
            if (s) m_sat = 1'b1;
            q1.push_back(e);
            q3.push_back(e);
            m_pos = (m_pos + 1) % BLK;
            n_vec++;
        end
        @(posedge clk);
        #1;
        chk("p1 sat_flag", o1_sat, m_sat);
        chk("p3 sat_flag", o3_sat, m_sat);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_dir    = 1'b0;
        in_bypass = 1'b0;
        in_r      = '0;
        in_i      = '0;
        rst       = 1'b1;
        #1;
        chk("p1 reset out_valid", o1_valid, 0);
        chk("p3 reset out_valid", o3_valid, 0);
        chk("p3 reset out_sof", o3_sof, 0);
        chk("p3 reset out_r", o3_r, 0);
        chk("p1 reset sat_flag", o1_sat, 0);
        chk("p3 reset sat_flag", o3_sat, 0);
        q1.delete();
        q3.delete();
        m_pos = 0;
        m_dir = 1'b1;
        m_sat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Ramp frame r=k, i=100+k; optional direction flip, gaps, bypass slot and saturating slot.
    task automatic frame(input bit dir, input int flip_k, input bit gaps,
                         input int byp_k, input int sat_k);
        for (int k = 0; k < BLK; k++) begin
            bit d;
            int r;
            d = (k >= flip_k) ? !dir : dir;
            r = (k == sat_k) ? MINV : k;
            if (gaps) apply(1'b0, 1'b1, !d, 1'b1, 7, 9);
            apply(1'b1, k == 0, d, k == byp_k, r, 100 + k);
        end
    endtask

    function automatic int rnd_val();
        if ($urandom_range(0, 7) == 0) return MINV;
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    initial begin
        rst = 1'b1;
        do_reset();

        frame(1'b1, BLK, 1'b0, -1, -1);
        frame(1'b0, BLK, 1'b0, -1, -1);
        frame(1'b1, 20, 1'b0, -1, -1);
        frame(1'b0, BLK, 1'b0, -1, 50);
        frame(1'b1, BLK, 1'b1, 50, -1);

        for (int n = 0; n < 800; n++) begin
            apply($urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0, rnd_val(), rnd_val());
        end

        apply(1'b1, 1'b1, 1'b0, 1'b0, 11, 12);
        for (int k = 1; k < 5; k++) apply(1'b1, 1'b0, 1'b0, 1'b0, k, -k);
        do_reset();
        for (int k = 0; k < 52; k++) apply(1'b1, 1'b0, 1'b0, 1'b0, 500 + k, -300 - k);
        for (int k = 0; k < 3; k++) apply(1'b1, 1'b0, 1'b1, 1'b0, MINV, MINV);

        repeat (6) apply(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("p1 drained", q1.size(), 0);
        chk("p3 drained", q3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got t=%0t, expected end before 500000", $time);
        $fatal(1, "watchdog");
    end
endmodule
